// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: captures decoded operands and controls for execute, with stall hold
// and flush-to-bubble. Define ID_EX_REFRESH_EN to refresh held operands from writeback on stall.
module id_ex_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [15:0] in_instr,
  input  logic [15:0] in_A,
  input  logic [15:0] in_B,
  input  logic [15:0] in_nextPC,
  input  logic [15:0] in_signExtend1,
  input  logic [15:0] in_signExtend2,
  input  logic [15:0] in_signExtend3,
  input  logic [15:0] in_zeroExtend1,
  input  logic [15:0] in_zeroExtend2,
  input  logic [2:0]  in_rs,
  input  logic [2:0]  in_rt,
  input  logic        in_SignExtend,
  input  logic        in_invA,
  input  logic        in_invB,
  input  logic        in_Cin,
  input  logic [1:0]  in_ALUSrc,
  input  logic [1:0]  in_RegDst,
  input  logic        in_RegWrite,
  input  logic        in_MemWrite,
  input  logic        in_MemRead,
  input  logic        in_MemToReg,
  input  logic        in_Halt,
  input  logic        wb_en,
  input  logic [2:0]  wb_reg,
  input  logic [15:0] wb_data,
  output logic        out_valid,
  output logic [15:0] out_instr,
  output logic [15:0] out_A,
  output logic [15:0] out_B,
  output logic [15:0] out_nextPC,
  output logic [15:0] out_signExtend1,
  output logic [15:0] out_signExtend2,
  output logic [15:0] out_signExtend3,
  output logic [15:0] out_zeroExtend1,
  output logic [15:0] out_zeroExtend2,
  output logic [2:0]  out_rs,
  output logic [2:0]  out_rt,
  output logic        out_SignExtend,
  output logic        out_invA,
  output logic        out_invB,
  output logic        out_Cin,
  output logic [1:0]  out_ALUSrc,
  output logic [1:0]  out_RegDst,
  output logic        out_RegWrite,
  output logic        out_MemWrite,
  output logic        out_MemRead,
  output logic        out_MemToReg,
  output logic        out_Halt,
  output logic        out_bubble
);

  typedef struct packed {
    logic        valid;
    logic [15:0] instr;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] next_pc;
    logic [15:0] se1;
    logic [15:0] se2;
    logic [15:0] se3;
    logic [15:0] ze1;
    logic [15:0] ze2;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic        sign_ext;
    logic        inv_a;
    logic        inv_b;
    logic        cin;
    logic [1:0]  alu_src;
    logic [1:0]  reg_dst;
    logic        reg_write;
    logic        mem_write;
    logic        mem_read;
    logic        mem_to_reg;
    logic        halt;
  } ex_t;

  // Bubble and reset share contents: a NOP with every control cleared.
  localparam ex_t Bubble = '{instr: 16'h0800, default: '0};

  ex_t  in_s, ex_d, ex_q;
  logic bubble_d, bubble_q;

  always_comb begin
    in_s            = '0;
    in_s.valid      = in_valid;
    in_s.instr      = in_instr;
    in_s.a          = in_A;
    in_s.b          = in_B;
    in_s.next_pc    = in_nextPC;
    in_s.se1        = in_signExtend1;
    in_s.se2        = in_signExtend2;
    in_s.se3        = in_signExtend3;
    in_s.ze1        = in_zeroExtend1;
    in_s.ze2        = in_zeroExtend2;
    in_s.rs         = in_rs;
    in_s.rt         = in_rt;
    in_s.sign_ext   = in_SignExtend;
    in_s.inv_a      = in_invA;
    in_s.inv_b      = in_invB;
    in_s.cin        = in_Cin;
    in_s.alu_src    = in_ALUSrc;
    in_s.reg_dst    = in_RegDst;
    // An empty decode slot must not touch architectural state downstream.
    in_s.reg_write  = in_RegWrite & in_valid;
    in_s.mem_write  = in_MemWrite & in_valid;
    in_s.mem_read   = in_MemRead  & in_valid;
    in_s.mem_to_reg = in_MemToReg & in_valid;
    in_s.halt       = in_Halt     & in_valid;
  end

  always_comb begin
    ex_d     = ex_q;
    bubble_d = bubble_q;
    if (flush) begin
      ex_d     = Bubble;
      bubble_d = 1'b1;
    end else if (stall) begin
`ifdef ID_EX_REFRESH_EN
      if (ex_q.valid && wb_en) begin
        if (wb_reg == ex_q.rs) ex_d.a = wb_data;
        if (wb_reg == ex_q.rt) ex_d.b = wb_data;
      end
`endif
    end else begin
      ex_d     = in_s;
      bubble_d = 1'b0;
    end
  end

`ifndef ID_EX_REFRESH_EN
  logic unused_wb;
  assign unused_wb = ^{wb_en, wb_reg, wb_data};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q     <= Bubble;
      bubble_q <= 1'b0;
    end else begin
      ex_q     <= ex_d;
      bubble_q <= bubble_d;
    end
  end

  assign out_valid       = ex_q.valid;
  assign out_instr       = ex_q.instr;
  assign out_A           = ex_q.a;
  assign out_B           = ex_q.b;
  assign out_nextPC      = ex_q.next_pc;
  assign out_signExtend1 = ex_q.se1;
  assign out_signExtend2 = ex_q.se2;
  assign out_signExtend3 = ex_q.se3;
  assign out_zeroExtend1 = ex_q.ze1;
  assign out_zeroExtend2 = ex_q.ze2;
  assign out_rs          = ex_q.rs;
  assign out_rt          = ex_q.rt;
  assign out_SignExtend  = ex_q.sign_ext;
  assign out_invA        = ex_q.inv_a;
  assign out_invB        = ex_q.inv_b;
  assign out_Cin         = ex_q.cin;
  assign out_ALUSrc      = ex_q.alu_src;
  assign out_RegDst      = ex_q.reg_dst;
  assign out_RegWrite    = ex_q.reg_write;
  assign out_MemWrite    = ex_q.mem_write;
  assign out_MemRead     = ex_q.mem_read;
  assign out_MemToReg    = ex_q.mem_to_reg;
  assign out_Halt        = ex_q.halt;
  assign out_bubble      = bubble_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Testbench for id_ex_reg: directed vector table, hand-written reset/refresh sequences and a
// randomized run checked against a reference model through an expected-value queue.
module tb_id_ex_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, flush, in_valid;
  logic [15:0] in_instr, in_A, in_B, in_nextPC;
  logic [15:0] in_signExtend1, in_signExtend2, in_signExtend3, in_zeroExtend1, in_zeroExtend2;
  logic [2:0]  in_rs, in_rt;
  logic        in_SignExtend, in_invA, in_invB, in_Cin;
  logic [1:0]  in_ALUSrc, in_RegDst;
  logic        in_RegWrite, in_MemWrite, in_MemRead, in_MemToReg, in_Halt;
  logic        wb_en;
  logic [2:0]  wb_reg;
  logic [15:0] wb_data;
  logic        out_valid;
  logic [15:0] out_instr, out_A, out_B, out_nextPC;
  logic [15:0] out_signExtend1, out_signExtend2, out_signExtend3;
  logic [15:0] out_zeroExtend1, out_zeroExtend2;
  logic [2:0]  out_rs, out_rt;
  logic        out_SignExtend, out_invA, out_invB, out_Cin;
  logic [1:0]  out_ALUSrc, out_RegDst;
  logic        out_RegWrite, out_MemWrite, out_MemRead, out_MemToReg, out_Halt, out_bubble;

  id_ex_reg dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_instr(in_instr), .in_A(in_A), .in_B(in_B), .in_nextPC(in_nextPC),
    .in_signExtend1(in_signExtend1), .in_signExtend2(in_signExtend2),
    .in_signExtend3(in_signExtend3), .in_zeroExtend1(in_zeroExtend1),
    .in_zeroExtend2(in_zeroExtend2), .in_rs(in_rs), .in_rt(in_rt),
    .in_SignExtend(in_SignExtend), .in_invA(in_invA), .in_invB(in_invB), .in_Cin(in_Cin),
    .in_ALUSrc(in_ALUSrc), .in_RegDst(in_RegDst), .in_RegWrite(in_RegWrite),
    .in_MemWrite(in_MemWrite), .in_MemRead(in_MemRead), .in_MemToReg(in_MemToReg),
    .in_Halt(in_Halt), .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .out_valid(out_valid), .out_instr(out_instr), .out_A(out_A), .out_B(out_B),
    .out_nextPC(out_nextPC), .out_signExtend1(out_signExtend1),
    .out_signExtend2(out_signExtend2), .out_signExtend3(out_signExtend3),
    .out_zeroExtend1(out_zeroExtend1), .out_zeroExtend2(out_zeroExtend2),
    .out_rs(out_rs), .out_rt(out_rt), .out_SignExtend(out_SignExtend), .out_invA(out_invA),
    .out_invB(out_invB), .out_Cin(out_Cin), .out_ALUSrc(out_ALUSrc), .out_RegDst(out_RegDst),
    .out_RegWrite(out_RegWrite), .out_MemWrite(out_MemWrite), .out_MemRead(out_MemRead),
    .out_MemToReg(out_MemToReg), .out_Halt(out_Halt), .out_bubble(out_bubble)
  );

  typedef struct packed {
    logic        valid;
    logic [15:0] instr, a, b, npc, se1, se2, se3, ze1, ze2;
    logic [2:0]  rs, rt;
    logic        sx, ia, ib, cin;
    logic [1:0]  alu_src, reg_dst;
    logic        rw, mw, mr, m2r, halt;
    logic        bubble;
  } st_t;

  typedef struct packed {
    logic [15:0] instr, a;
    logic        valid, rw, mw, halt, bubble;
  } key_t;

  typedef struct {
    logic stall, flush, valid;
    logic [15:0] instr, a;
    logic rw, mw, halt;
    key_t exp;
  } vec_t;

  int   n_err = 0;
  int   n_chk = 0;
  st_t  reset_st, mdl;
  st_t  exp_q[$];
  key_t key_q[$];
  vec_t vecs[12];

  function automatic st_t get_out();
    return '{out_valid, out_instr, out_A, out_B, out_nextPC, out_signExtend1, out_signExtend2,
             out_signExtend3, out_zeroExtend1, out_zeroExtend2, out_rs, out_rt, out_SignExtend,
             out_invA, out_invB, out_Cin, out_ALUSrc, out_RegDst, out_RegWrite, out_MemWrite,
             out_MemRead, out_MemToReg, out_Halt, out_bubble};
  endfunction

  function automatic st_t model(st_t cur, st_t in, logic stl, logic fl,
                                logic wen, logic [2:0] wreg, logic [15:0] wd);
    st_t n;
    if (fl) begin
      n = '0; n.instr = 16'h0800; n.bubble = 1'b1;
    end else if (stl) begin
      n = cur;
`ifdef ID_EX_REFRESH_EN
      if (cur.valid && wen) begin
        if (wreg == cur.rs) n.a = wd;
        if (wreg == cur.rt) n.b = wd;
      end
`endif
    end else begin
      n = in; n.bubble = 1'b0;
      if (!in.valid) {n.rw, n.mw, n.mr, n.m2r, n.halt} = '0;
    end
    return n;
  endfunction

  task automatic apply(input st_t i);
    in_valid = i.valid; in_instr = i.instr; in_A = i.a; in_B = i.b; in_nextPC = i.npc;
    in_signExtend1 = i.se1; in_signExtend2 = i.se2; in_signExtend3 = i.se3;
    in_zeroExtend1 = i.ze1; in_zeroExtend2 = i.ze2; in_rs = i.rs; in_rt = i.rt;
    in_SignExtend = i.sx; in_invA = i.ia; in_invB = i.ib; in_Cin = i.cin;
    in_ALUSrc = i.alu_src; in_RegDst = i.reg_dst; in_RegWrite = i.rw; in_MemWrite = i.mw;
    in_MemRead = i.mr; in_MemToReg = i.m2r; in_Halt = i.halt;
  endtask

  task automatic check_st(input string name, input st_t act, input st_t exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    st_t  r, cur;
    key_t k, ke;
    logic [$bits(st_t)-1:0] bits;

    reset_st = '0; reset_st.instr = 16'h0800;
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    wb_en = 1'b0; wb_reg = '0; wb_data = '0;
    apply('0);
    tick();
    check_st("reset_initial", get_out(), reset_st);
    rst = 1'b0;

    // Directed table: {stall, flush, valid, instr, a, rw, mw, halt} -> key outputs.
    vecs[0]  = '{0, 0, 1, 16'hD8A4, 16'h0005, 1, 0, 0, '{16'hD8A4, 16'h0005, 1, 1, 0, 0, 0}};
    vecs[1]  = '{0, 0, 1, 16'h1000, 16'h1111, 0, 0, 0, '{16'h1000, 16'h1111, 1, 0, 0, 0, 0}};
    vecs[2]  = '{1, 0, 1, 16'h2000, 16'h2222, 0, 0, 0, '{16'h1000, 16'h1111, 1, 0, 0, 0, 0}};
    vecs[3]  = '{1, 0, 1, 16'h2000, 16'h2222, 0, 0, 0, '{16'h1000, 16'h1111, 1, 0, 0, 0, 0}};
    vecs[4]  = '{1, 0, 1, 16'h2000, 16'h2222, 0, 0, 0, '{16'h1000, 16'h1111, 1, 0, 0, 0, 0}};
    vecs[5]  = '{0, 0, 1, 16'h2000, 16'h2222, 0, 0, 0, '{16'h2000, 16'h2222, 1, 0, 0, 0, 0}};
    vecs[6]  = '{1, 1, 1, 16'h3000, 16'h3333, 0, 1, 0, '{16'h0800, 16'h0000, 0, 0, 0, 0, 1}};
    vecs[7]  = '{1, 0, 1, 16'h4000, 16'h4444, 0, 1, 0, '{16'h0800, 16'h0000, 0, 0, 0, 0, 1}};
    vecs[8]  = '{0, 0, 0, 16'h5000, 16'h5555, 1, 1, 1, '{16'h5000, 16'h5555, 0, 0, 0, 0, 0}};
    vecs[9]  = '{0, 0, 1, 16'h6000, 16'h6666, 0, 1, 1, '{16'h6000, 16'h6666, 1, 0, 1, 1, 0}};
    vecs[10] = '{0, 1, 1, 16'h7000, 16'h7777, 1, 1, 1, '{16'h0800, 16'h0000, 0, 0, 0, 0, 1}};
    vecs[11] = '{0, 0, 1, 16'h8000, 16'h8888, 1, 0, 0, '{16'h8000, 16'h8888, 1, 1, 0, 0, 0}};

    foreach (vecs[i]) begin
      r = '0;
      r.valid = vecs[i].valid; r.instr = vecs[i].instr; r.a = vecs[i].a;
      r.rw = vecs[i].rw; r.mw = vecs[i].mw; r.halt = vecs[i].halt;
      stall = vecs[i].stall; flush = vecs[i].flush;
      apply(r);
      key_q.push_back(vecs[i].exp);
      tick();
      k = '{out_instr, out_A, out_valid, out_RegWrite, out_MemWrite, out_Halt, out_bubble};
      n_chk++;
      if (key_q.size() == 0) begin
        n_err++;
        $display("FAIL vec%0d: expected queue empty", i);
      end else begin
        ke = key_q.pop_front();
        if (k !== ke) begin
          n_err++;
          $display("FAIL vec%0d: got %h expected %h", i, k, ke);
        end
      end
    end

    // Asynchronous reset mid-cycle, then release while stalled.
    @(negedge clk);
    #2;
    r = '0; r.valid = 1'b1; r.instr = 16'h4123; r.rw = 1'b1;
    apply(r);
    stall = 1'b0; flush = 1'b0;
    rst = 1'b1;
    #1;
    check_st("reset_async", get_out(), reset_st);
    tick();
    stall = 1'b1;
    rst = 1'b0;
    tick();
    check_st("reset_release_stall1", get_out(), reset_st);
    tick();
    check_st("reset_release_stall2", get_out(), reset_st);
    stall = 1'b0;
    tick();
    check16("first_load_after_reset", out_instr, 16'h4123);

    // Operand refresh while stalled with rs == rt.
    r = '0; r.valid = 1'b1; r.a = 16'h0001; r.b = 16'h0002; r.rs = 3'd3; r.rt = 3'd3;
    apply(r);
    tick();
    stall = 1'b1; wb_en = 1'b1; wb_reg = 3'd3; wb_data = 16'hBEEF;
    r.a = 16'h7777; r.b = 16'h7777;
    apply(r);
    tick();
`ifdef ID_EX_REFRESH_EN
    check16("refresh_A", out_A, 16'hBEEF);
    check16("refresh_B", out_B, 16'hBEEF);
`else
    check16("refresh_A", out_A, 16'h0001);
    check16("refresh_B", out_B, 16'h0002);
`endif
    // Refresh must not act on an invalid slot.
    stall = 1'b0; wb_en = 1'b0;
    r.valid = 1'b0; r.a = 16'h0011;
    apply(r);
    tick();
    stall = 1'b1; wb_en = 1'b1;
    tick();
    check16("refresh_invalid_A", out_A, 16'h0011);
    stall = 1'b0; wb_en = 1'b0;

    // Randomized run against the reference model.
    tick();
    mdl = get_out();
    check_st("rand_start", mdl, model(mdl, r, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0));
    for (int c = 0; c < 200; c++) begin
      for (int b = 0; b < $bits(st_t); b++) bits[b] = 1'($urandom_range(0, 1));
      r = st_t'(bits);
      r.bubble = 1'b0;
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 9) == 0);
      wb_en = 1'($urandom_range(0, 1));
      wb_reg = 3'($urandom_range(0, 7));
      wb_data = 16'($urandom);
      apply(r);
      mdl = model(mdl, r, stall, flush, wb_en, wb_reg, wb_data);
      exp_q.push_back(mdl);
      tick();
      if (exp_q.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL rand%0d: expected queue empty", c);
      end else begin
        cur = exp_q.pop_front();
        check_st($sformatf("rand%0d", c), get_out(), cur);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
